// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller for the MIPS execute stage: decodes the I/O region,
// buffers RX/TX bytes in circular FIFOs, and exposes status, cycle counter and overflow flag.
module uart_mmio_ctrl #(
    parameter int          DATA_W   = 8,
    parameter int          RX_DEPTH = 8,
    parameter int          TX_DEPTH = 8,
    parameter logic [3:0]  REGION   = 4'h8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              re,
    input  logic              we,
    input  logic [31:0]       wdata,
    input  logic              stall,
    output logic              hit,
    output logic [31:0]       rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;

    localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);

    localparam logic [5:0] OFF_TX_STAT = 6'd0;
    localparam logic [5:0] OFF_RX_STAT = 6'd1;
    localparam logic [5:0] OFF_RX_DATA = 6'd2;
    localparam logic [5:0] OFF_TX_DATA = 6'd3;
    localparam logic [5:0] OFF_CNT     = 6'd4;
    localparam logic [5:0] OFF_STATUS  = 6'd5;

    logic [DATA_W-1:0] rx_mem_r [RX_DEPTH];
    logic [RX_AW-1:0]  rx_rd_ptr_r;
    logic [RX_AW-1:0]  rx_wr_ptr_r;
    logic [RX_CW-1:0]  rx_count_r;

    logic [DATA_W-1:0] tx_mem_r [TX_DEPTH];
    logic [TX_AW-1:0]  tx_rd_ptr_r;
    logic [TX_AW-1:0]  tx_wr_ptr_r;
    logic [TX_CW-1:0]  tx_count_r;

    logic [31:0] cycle_cnt_r;
    logic        tx_ovf_r;

    logic [5:0] offset_s;
    logic       cpu_rd_s;
    logic       cpu_wr_s;
    logic       rx_empty_s;
    logic       tx_full_s;
    logic       rx_push_s;
    logic       rx_pop_s;
    logic       tx_push_req_s;
    logic       tx_push_s;
    logic       tx_pop_s;
    logic       tx_ovf_set_s;
    logic       tx_ovf_clr_s;
    logic       cnt_clr_s;
    logic       unused_s;

    assign hit      = (addr[31:28] == REGION);
    assign offset_s = addr[7:2];

    // A store wins over a load; stall masks both.
    assign cpu_wr_s = hit & we & ~stall;
    assign cpu_rd_s = hit & re & ~we & ~stall;

    assign rx_empty_s = (rx_count_r == {RX_CW{1'b0}});
    assign tx_full_s  = (tx_count_r == TX_FULL);
    assign rx_ready   = (rx_count_r != RX_FULL);
    assign tx_valid   = (tx_count_r != {TX_CW{1'b0}});
    assign tx_data    = tx_mem_r[tx_rd_ptr_r];

    assign rx_push_s     = rx_valid & rx_ready;
    assign rx_pop_s      = cpu_rd_s & (offset_s == OFF_RX_DATA) & ~rx_empty_s;
    assign tx_pop_s      = tx_valid & tx_ready;
    assign tx_push_req_s = cpu_wr_s & (offset_s == OFF_TX_DATA);
    // A full TX FIFO still accepts a byte when the head leaves in the same cycle.
    assign tx_push_s     = tx_push_req_s & (~tx_full_s | tx_pop_s);
    assign tx_ovf_set_s  = tx_push_req_s & tx_full_s & ~tx_pop_s;
    assign tx_ovf_clr_s  = cpu_wr_s & (offset_s == OFF_STATUS) & wdata[16];
    assign cnt_clr_s     = cpu_wr_s & (offset_s == OFF_CNT);

    assign unused_s = ^{addr[27:8], addr[1:0], wdata};

    // Register read mux; only the addressed register drives rdata.
    always_comb begin
        rdata = 32'h0000_0000;
        if (hit) begin
            case (offset_s)
                OFF_TX_STAT: rdata = {31'd0, ~tx_full_s};
                OFF_RX_STAT: rdata = {31'd0, ~rx_empty_s};
                OFF_RX_DATA: begin
                    if (rx_empty_s) begin
                        rdata = 32'h0000_0000;
                    end else begin
                        rdata = 32'(rx_mem_r[rx_rd_ptr_r]);
                    end
                end
                OFF_CNT:     rdata = cycle_cnt_r;
                OFF_STATUS:  rdata = {15'd0, tx_ovf_r, 8'(rx_count_r), 8'(tx_count_r)};
                default:     rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // RX storage write port.
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= rx_data;
        end
    end

    // RX pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_rd_ptr_r <= {RX_AW{1'b0}};
            rx_wr_ptr_r <= {RX_AW{1'b0}};
            rx_count_r  <= {RX_CW{1'b0}};
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + RX_AW'(1);
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + RX_AW'(1);
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + RX_CW'(1);
                2'b01:   rx_count_r <= rx_count_r - RX_CW'(1);
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // TX storage write port.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r] <= wdata[DATA_W-1:0];
        end
    end

    // TX pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_rd_ptr_r <= {TX_AW{1'b0}};
            tx_wr_ptr_r <= {TX_AW{1'b0}};
            tx_count_r  <= {TX_CW{1'b0}};
        end else begin
            if (tx_push_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + TX_AW'(1);
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + TX_AW'(1);
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + TX_CW'(1);
                2'b01:   tx_count_r <= tx_count_r - TX_CW'(1);
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // Sticky TX overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf_r <= 1'b0;
        end else if (tx_ovf_set_s) begin
            tx_ovf_r <= 1'b1;
        end else if (tx_ovf_clr_s) begin
            tx_ovf_r <= 1'b0;
        end else begin
            tx_ovf_r <= tx_ovf_r;
        end
    end

    // Free-running cycle counter; keeps counting through stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_r <= 32'h0000_0000;
        end else if (cnt_clr_s) begin
            cycle_cnt_r <= 32'h0000_0000;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed self-checking bench for uart_mmio_ctrl with hand-computed expectations.
module tb_uart_mmio_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic        stall;
    logic        hit;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int passed = 0;
    int total  = 0;

    uart_mmio_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .re       (re),
        .we       (we),
        .wdata    (wdata),
        .stall    (stall),
        .hit      (hit),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Look at a register without issuing a load.
    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        re   = 1'b0;
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        bit seen;
        reset = 1'b1; addr = 32'h0; re = 1'b0; we = 1'b0; wdata = 32'h0;
        stall = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        tick();
        tick();

        // Reset state
        peek("rst_txstat", 32'h8000_0000, 32'h0000_0001);
        peek("rst_rxstat", 32'h8000_0004, 32'h0000_0000);
        peek("rst_status", 32'h8000_0014, 32'h0000_0000);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("hit_in", 32'(hit), 32'd1);
        peek("miss_rdata", 32'h3000_0000, 32'h0000_0000);
        chk("hit_out", 32'(hit), 32'd0);
        reset = 1'b0;

        // Counter: five edges after reset
        repeat (5) tick();
        peek("cnt_5", 32'h8000_0010, 32'd5);
        we = 1'b1;
        tick();
        we = 1'b0;
        #1;
        chk("cnt_clr0", rdata, 32'd0);
        tick();
        chk("cnt_clr1", rdata, 32'd1);

        // RX ordering
        rx_valid = 1'b1; rx_data = 8'h41;
        peek("rx_lat0", 32'h8000_0004, 32'd0);
        tick();
        rx_data = 8'h42;
        peek("rx_lat1", 32'h8000_0004, 32'd1);
        tick();
        rx_data = 8'h43;
        tick();
        rx_valid = 1'b0;
        addr = 32'h8000_0008; re = 1'b1;
        #1;
        chk("rx_pop0", rdata, 32'h41);
        tick();
        chk("rx_pop1", rdata, 32'h42);
        tick();
        chk("rx_pop2", rdata, 32'h43);
        tick();
        chk("rx_empty_rd", rdata, 32'h0);
        tick();
        peek("rx_empty_st", 32'h8000_0014, 32'h0);
        rx_valid = 1'b1; rx_data = 8'h44;
        tick();
        rx_valid = 1'b0;
        peek("rx_ptr_keep", 32'h8000_0008, 32'h44);
        re = 1'b1;
        tick();
        peek("rx_drained", 32'h8000_0004, 32'd0);

        // TX overflow
        peek("tx_notfull", 32'h8000_0000, 32'd1);
        for (int i = 0; i < 9; i++) begin
            addr = 32'h8000_000C; we = 1'b1; wdata = 32'h0000_0010 + 32'(i);
            tick();
        end
        we = 1'b0;
        peek("tx_ovf_st", 32'h8000_0014, 32'h0001_0008);
        peek("tx_full", 32'h8000_0000, 32'd0);
        chk("tx_head", 32'(tx_data), 32'h10);
        addr = 32'h8000_0014; we = 1'b1; wdata = 32'h0001_0000;
        tick();
        we = 1'b0;
        peek("tx_ovf_clr", 32'h8000_0014, 32'h0000_0008);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("tx_drain_v", 32'(tx_valid), 32'd1);
            chk("tx_drain_d", 32'(tx_data), 32'h10 + 32'(i));
            tick();
        end
        chk("tx_empty", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // Full TX with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            addr = 32'h8000_000C; we = 1'b1; wdata = 32'h0000_0020 + 32'(i);
            tick();
        end
        tx_ready = 1'b1; wdata = 32'h0000_0028;
        tick();
        we = 1'b0; tx_ready = 1'b0;
        peek("tx_full_pp", 32'h8000_0014, 32'h0000_0008);
        chk("tx_full_pp_head", 32'(tx_data), 32'h21);
        tx_ready = 1'b1;
        repeat (8) tick();
        tx_ready = 1'b0;
        #1;
        chk("tx_empty2", 32'(tx_valid), 32'd0);

        // RX full: pop accepted, push refused
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'h50 + 8'(i);
            tick();
        end
        chk("rx_full_rdy", 32'(rx_ready), 32'd0);
        peek("rx_full_st", 32'h8000_0014, 32'h0000_0800);
        rx_data = 8'h5F; re = 1'b1; addr = 32'h8000_0008;
        #1;
        chk("rx_full_pop", rdata, 32'h50);
        tick();
        re = 1'b0; rx_valid = 1'b0;
        #1;
        chk("rx_rdy_back", 32'(rx_ready), 32'd1);
        peek("rx_cnt7", 32'h8000_0014, 32'h0000_0700);

        // Stalled load leaves the FIFO alone
        addr = 32'h8000_0008; re = 1'b1; stall = 1'b1;
        #1;
        chk("stall_head", rdata, 32'h51);
        tick();
        chk("stall_keep", rdata, 32'h51);
        peek("stall_cnt", 32'h8000_0014, 32'h0000_0700);
        addr = 32'h8000_0008; re = 1'b1; stall = 1'b0;
        tick();
        peek("unstall_pop", 32'h8000_0008, 32'h52);
        peek("unstall_cnt", 32'h8000_0014, 32'h0000_0600);

        // Counter wrap
        addr = 32'h8000_0010;
        force dut.cycle_cnt_r = 32'hFFFF_FFFF;
        #1;
        chk("cnt_max", rdata, 32'hFFFF_FFFF);
        tick();
        release dut.cycle_cnt_r;
        seen = 1'b0;
        for (int k = 0; k < 3 && !seen; k++) begin
            #1;
            if (rdata == 32'h0) seen = 1'b1;
            else tick();
        end
        chk("cnt_wrap", 32'(seen), 32'd1);

        // Reset discards in-flight FIFO contents
        addr = 32'h8000_000C; we = 1'b1; wdata = 32'h0000_0077;
        tick();
        we = 1'b0; rx_valid = 1'b1; rx_data = 8'h88;
        tick();
        rx_valid = 1'b0; tx_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; tx_ready = 1'b0;
        #1;
        chk("rst_mid_txv", 32'(tx_valid), 32'd0);
        peek("rst_mid_st", 32'h8000_0014, 32'h0);
        peek("rst_mid_rx", 32'h8000_0004, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
